// File: rtl/rate_detector.sv
// Tick interval meter: measures cycles between tick pulses, classifies each
// interval into a 2-bit speed code and locks when two consecutive codes agree.
module rate_detector #(
  parameter int BASE_LOG2 = 26,
  parameter int CNT_W     = BASE_LOG2 + 3,
  parameter int TOL       = 2
) (
  input  logic             CLOCK_50,
  input  logic             Clear,
  input  logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic [1:0]       rate_code,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int EXT_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [EXT_W-1:0] EXT_ONE  = {{(EXT_W-1){1'b0}}, 1'b1};
  localparam logic [EXT_W-1:0] TOL_X    = EXT_W'(TOL);

  // True when val lies within TOL of 2^shift; unsigned, one bit wider than the counter.
  function automatic logic near_pow2(input logic [EXT_W-1:0] val, input int shift);
    logic [EXT_W-1:0] tgt;
    logic [EXT_W-1:0] diff;
    tgt = EXT_ONE << shift;
    if (val >= tgt) begin
      diff = val - tgt;
    end else begin
      diff = tgt - val;
    end
    return (diff <= TOL_X);
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] period_r;
  logic             valid_r;
  logic [1:0]       rate_code_r;
  logic             locked_r;
  logic             timeout_r;
  logic [1:0]       prev_code_r;
  logic             prev_ok_r;

  logic [EXT_W-1:0] cnt_x_s;
  logic [1:0]       code_s;
  logic             code_ok_s;
  logic             match_s;

  assign cnt_x_s = {1'b0, cnt_r};

  // Classify the running count as it would be captured on a closing tick.
  always_comb begin
    code_s    = 2'd0;
    code_ok_s = 1'b0;
    if (cnt_r == CNT_ONE) begin
      code_s    = 2'd0;
      code_ok_s = 1'b1;
    end else if (near_pow2(cnt_x_s, BASE_LOG2)) begin
      code_s    = 2'd1;
      code_ok_s = 1'b1;
    end else if (near_pow2(cnt_x_s, BASE_LOG2 + 1)) begin
      code_s    = 2'd2;
      code_ok_s = 1'b1;
    end else if (near_pow2(cnt_x_s, BASE_LOG2 + 2)) begin
      code_s    = 2'd3;
      code_ok_s = 1'b1;
    end else begin
      code_s    = 2'd0;
      code_ok_s = 1'b0;
    end
  end

  assign match_s = code_ok_s && prev_ok_r && (code_s == prev_code_r);

  // Measurement FSM with registered result outputs.
  always_ff @(posedge CLOCK_50 or negedge Clear) begin
    if (!Clear) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      period_r    <= CNT_ZERO;
      valid_r     <= 1'b0;
      rate_code_r <= 2'd0;
      locked_r    <= 1'b0;
      timeout_r   <= 1'b0;
      prev_code_r <= 2'd0;
      prev_ok_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick) begin
            cnt_r   <= CNT_ONE;
            state_r <= MEASURE;
          end else begin
            cnt_r <= CNT_ZERO;
          end
        end
        MEASURE: begin
          if (tick) begin
            // Closing tick: capture, classify and restart on the same edge.
            period_r    <= cnt_r;
            valid_r     <= 1'b1;
            timeout_r   <= 1'b0;
            cnt_r       <= CNT_ONE;
            prev_code_r <= code_s;
            prev_ok_r   <= code_ok_s;
            if (match_s) begin
              locked_r    <= 1'b1;
              rate_code_r <= code_s;
            end else begin
              locked_r <= 1'b0;
            end
          end else if (cnt_r == CNT_MAX) begin
            timeout_r <= 1'b1;
            locked_r  <= 1'b0;
            prev_ok_r <= 1'b0;
            cnt_r     <= CNT_ZERO;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign period    = period_r;
  assign valid     = valid_r;
  assign rate_code = rate_code_r;
  assign locked    = locked_r;
  assign timeout   = timeout_r;

endmodule

// File: doc/rate_detector.md
Name: rate_detector

Overview:
- Measures the interval, in clock cycles, between consecutive single-cycle tick pulses, such as a rate divider's terminal-count enable.
- Classifies each measured interval into the same 2-bit speed-select code that the rate dividers consume:
  - 0 = every cycle
  - 1 = 2^BASE_LOG2 cycles
  - 2 = 2^(BASE_LOG2+1) cycles
  - 3 = 2^(BASE_LOG2+2) cycles
- Sits downstream of a divider, so a board self-check or the verification bench can confirm the selected rate. The measured period can be driven to hexseg displays.

Parameters:
- BASE_LOG2, 26, log2 of the code-1 period; sims use 4.
- CNT_W, BASE_LOG2+3, width of the period counter and the period output.
- TOL, 2, allowed ± cycles of deviation when matching codes 1–3. Code 0 requires an exact match.

Ports:
- CLOCK_50  input  1  system clock; all logic acts on the rising edge.
- Clear  input  1  asynchronous, active-low reset.
- tick  input  1  pulse input, sampled each rising edge.
- period  output  CNT_W  last measured interval in cycles.
- valid  output  1  one-cycle strobe that marks a new period value.
- rate_code  output  2  last locked speed code.
- locked  output  1  high when the last two periods matched the same code.
- timeout  output  1  sticky flag: no tick arrived within the counter range.

Behaviour:
- Reset (Clear=0, asynchronous):
  - State goes to IDLE.
  - cnt=0, period=0, valid=0, rate_code=0, locked=0, timeout=0, prev_code=invalid.
- States: IDLE, MEASURE.
- IDLE:
  - cnt holds at 0.
  - tick=1 → cnt=1, go to MEASURE. No valid strobe is issued, because the first tick only starts the measurement.
- MEASURE, tick=0:
  - cnt increments.
  - If cnt = 2^CNT_W−1 and tick=0: timeout=1, locked=0, prev_code=invalid, go to IDLE. period and rate_code hold their values.
- MEASURE, tick=1 (no increment on that edge):
  - period ← cnt, so back-to-back ticks give period=1.
  - valid=1 for exactly one cycle, on the edge after the tick is sampled.
  - cnt ← 1; stay in MEASURE.
- Classification of cnt, done in the same edge as the capture:
  - code 0 if cnt==1.
  - code k (k=1..3) if |cnt − 2^(BASE_LOG2+k−1)| ≤ TOL.
  - otherwise the interval is invalid.
  - The comparison is unsigned, CNT_W+1 bits wide, with no wrap.
- Lock update on each captured period:
  - If the code is valid and equals prev_code: locked=1, rate_code ← code.
  - Otherwise: locked=0, and rate_code holds its value.
  - prev_code ← code (or invalid).
- timeout clears on the next valid strobe.
- A tick while in IDLE after a timeout restarts the measurement exactly like the first tick after reset.
- Clear asserted mid-measurement: all state returns to reset values immediately, with no partial valid strobe.
- Continuous tick (tick held high): behaves as back-to-back ticks; period=1 every cycle and valid stays high.
- Latency: period, valid, locked and rate_code all update on the same edge that samples the closing tick.

Test Plan:
All scenarios use BASE_LOG2=4, CNT_W=7, TOL=2.
1. Reset, then tick held high for 5 cycles → no valid on the first tick. valid=1 on each following edge with period=1. locked=1 and rate_code=0 from the third tick onward.
2. Ticks every 16 cycles (three ticks) → period=16 twice; locked=1, rate_code=1 after the third tick.
3. Ticks with intervals 32, 34, 40 → period=32 then 34, giving locked=1 and rate_code=2. Then period=40 is invalid, so locked=0 while rate_code stays 2.
4. One tick, then no tick for 130 cycles → after 127 counts timeout=1, locked=0, state returns to IDLE. The next two ticks, 64 apart, give period=64, valid=1 and timeout=0.
5. Clear pulsed low mid-interval during a locked code-3 sequence → outputs are zero at once. The next tick produces no valid; the following tick, 64 later, gives period=64 with locked=0.
6. Intervals 16 then 32 → codes differ, so locked stays 0 and rate_code stays 0.
